// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT / SCAN / FILL / ALT patterns stepped by a prescaler, PWM-dimmed.
// Latency: tick is registered one cycle after the qualifying prescaler cycle; led lags pattern/gate by one cycle.
// Backpressure: none; en=0 freezes prescaler and pattern state while PWM keeps running.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous active-high reset
//   en     - run enable for prescaler and pattern state
//   mode   - pattern select (0 COUNT, 1 SCAN, 2 FILL, 3 ALT)
//   bright - PWM duty select (all-ones = always on, 0 = off)
//   led    - registered LED drive, pattern & gate
//   tick   - registered one-cycle pulse per pattern step
module led_pattern_gen #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_BITS = 23,
  parameter int PWM_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  output logic [WIDTH-1:0]    led,
  output logic                tick
);

  localparam int POS_BITS  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FILL_BITS = $clog2(WIDTH + 1);
  localparam logic [POS_BITS-1:0]  POS_MAX  = POS_BITS'(WIDTH - 1);
  localparam logic [FILL_BITS-1:0] FILL_MAX = FILL_BITS'(WIDTH);

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  logic [PRESCALE_BITS-1:0] r_presc;
  logic [PWM_BITS-1:0]      r_pwm_cnt;
  mode_e                    r_mode;
  logic [WIDTH-1:0]         r_count;
  logic [POS_BITS-1:0]      r_pos;
  logic                     r_dir_up;
  logic [FILL_BITS-1:0]     r_fill;
  logic                     r_alt_ph;   // 0: ...0101, 1: ...1010
  logic [WIDTH-1:0]         r_led;
  logic                     r_tick;

  logic                     w_mode_chg;
  logic                     w_step;
  logic                     w_gate;
  logic [POS_BITS-1:0]      w_pos_nxt;
  logic [WIDTH-1:0]         w_scan_mask;
  logic [WIDTH-1:0]         w_fill_mask;
  logic [WIDTH-1:0]         w_alt_mask;
  logic [WIDTH-1:0]         w_pattern;

  // A mode change restarts everything and suppresses any step in that cycle.
  assign w_mode_chg = (mode != r_mode);
  assign w_step     = en & (&r_presc) & ~w_mode_chg;
  assign w_gate     = (&bright) | (r_pwm_cnt < bright);
  assign w_pos_nxt  = r_dir_up ? (r_pos + 1'b1) : (r_pos - 1'b1);

  always_comb begin
    w_scan_mask = '0;
    w_fill_mask = '0;
    w_alt_mask  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_scan_mask[i] = (POS_BITS'(i) == r_pos);
      w_fill_mask[i] = (FILL_BITS'(i) < r_fill);
      w_alt_mask[i]  = ((i % 2) == 0) ? ~r_alt_ph : r_alt_ph;
    end
  end

  always_comb begin
    w_pattern = '0;
    case (r_mode)
      MODE_COUNT: w_pattern = r_count;
      MODE_SCAN:  w_pattern = w_scan_mask;
      MODE_FILL:  w_pattern = w_fill_mask;
      MODE_ALT:   w_pattern = w_alt_mask;
      default:    w_pattern = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_mode    <= MODE_COUNT;
      r_count   <= '0;
      r_pos     <= '0;
      r_dir_up  <= 1'b1;
      r_fill    <= '0;
      r_alt_ph  <= 1'b0;
      r_led     <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= w_pattern & {WIDTH{w_gate}};
      r_tick    <= w_step;

      if (w_mode_chg) begin
        r_mode   <= mode_e'(mode);
        r_presc  <= '0;
        r_count  <= '0;
        r_pos    <= '0;
        r_dir_up <= 1'b1;
        r_fill   <= '0;
        r_alt_ph <= 1'b0;
      end else begin
        if (en) begin
          r_presc <= r_presc + 1'b1;
        end
        // All pattern states advance together; inactive ones are cleared on the next mode change anyway.
        if (w_step) begin
          r_count  <= r_count + 1'b1;
          r_pos    <= w_pos_nxt;
          // Flip direction on the step that lands on an end so the ends are not repeated.
          if (r_dir_up && (w_pos_nxt == POS_MAX)) begin
            r_dir_up <= 1'b0;
          end else if (!r_dir_up && (w_pos_nxt == '0)) begin
            r_dir_up <= 1'b1;
          end
          r_fill   <= (r_fill == FILL_MAX) ? '0 : (r_fill + 1'b1);
          r_alt_ph <= ~r_alt_ph;
        end
      end
    end
  end

  assign led  = r_led;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] bright = 4'hF;
  logic [7:0] led;
  logic       tick;
  logic [3:0] led4;
  logic       tick4;

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(8), .PRESCALE_BITS(2), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bright(bright), .led(led), .tick(tick)
  );

  led_pattern_gen #(.WIDTH(4), .PRESCALE_BITS(2), .PWM_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .bright(bright), .led(led4), .tick(tick4)
  );

  typedef struct {
    bit         rst_first;
    logic [1:0] mode;
    bit         sel;        // 0: 8-bit instance, 1: 4-bit instance
    logic [7:0] exp;
    string      nm;
  } vec_t;

  typedef struct {
    bit         sel;
    logic [7:0] exp;
    string      nm;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   tick_seen = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // led is compared one sampled cycle after the tick that announced the step.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (tick_seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel) check(e.nm, 32'(led4), 32'(e.exp[3:0]));
      else       check(e.nm, 32'(led), 32'(e.exp));
    end
    tick_seen = (sb_q.size() > 0 && sb_q[0].sel) ? tick4 : tick;
  end

  task automatic push(input bit sel, input logic [7:0] exp, input string nm);
    sb_t e;
    e.sel = sel; e.exp = exp; e.nm = nm;
    sb_q.push_back(e);
  endtask

  // Returns at posedge+1 once the scoreboard is empty, or flags a timeout.
  task automatic drain(input string nm);
    int t = 0;
    while (sb_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb_q.size() != 0) begin
      check({nm, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1;
    en  = 1'b0;
    mode = m;
    bright = 4'hF;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    int on_cnt;
    int bad_cnt;
    int cnt;

    vecs.push_back('{1'b1, 2'd1, 1'b1, 8'h02, "scan"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 8'h04, "scan"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 8'h08, "scan"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 8'h04, "scan"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 8'h02, "scan"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 8'h01, "scan"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 8'h02, "scan"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8'h01, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h03, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h07, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h0F, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h1F, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h3F, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h7F, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'hFF, "fill"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 8'h00, "fill"});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8'hAA, "alt"});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 8'h55, "alt"});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 8'hAA, "alt"});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 8'h01, "count"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h02, "count"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h03, "count"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h04, "count"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h05, "count"});

    // Async reset before any clock edge.
    #2 rst = 1'b1;
    #2;
    check("reset_led", 32'(led), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_led4", 32'(led4), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) do_reset(vecs[i].mode);
      push(vecs[i].sel, vecs[i].exp, vecs[i].nm);
      drain(vecs[i].nm);
    end

    // Counter at 5, prescaler at 2. Switch mode in the cycle the prescaler is all-ones.
    check("pre_switch_led", 32'(led), 32'h05);
    @(posedge clk); #1;
    mode = 2'd3;
    @(posedge clk); #1;
    check("switch_no_tick", 32'(tick), 32'd0);
    @(posedge clk); #1;
    check("switch_led_55", 32'(led), 32'h55);
    check("switch_tick_a", 32'(tick), 32'd0);
    @(posedge clk); #1;
    check("switch_tick_b", 32'(tick), 32'd0);
    @(posedge clk); #1;
    check("switch_tick_c", 32'(tick), 32'd0);
    @(posedge clk); #1;
    check("switch_tick_step", 32'(tick), 32'd1);
    @(posedge clk); #1;
    check("switch_led_AA", 32'(led), 32'hAA);

    // Full COUNT run up to 255.
    do_reset(2'd0);
    for (int k = 1; k < 256; k++) begin
      push(1'b0, 8'(k), "count_run");
      drain("count_run");
    end

    // Frozen at 0xFF: PWM dimming, then off, then full on.
    en = 1'b0;
    bright = 4'd4;
    on_cnt = 0; bad_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      if (led === 8'hFF) on_cnt++;
      else if (led !== 8'h00) bad_cnt++;
      if (tick !== 1'b0) bad_cnt++;
    end
    check("pwm_b4_on_cycles", 32'(on_cnt), 32'd8);
    check("pwm_b4_other", 32'(bad_cnt), 32'd0);
    bright = 4'd0;
    on_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      if (led !== 8'h00) on_cnt++;
    end
    check("pwm_b0_nonzero", 32'(on_cnt), 32'd0);
    bright = 4'hF;
    @(posedge clk); #1;
    bad_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (led !== 8'hFF || tick !== 1'b0) bad_cnt++;
    end
    check("en0_hold", 32'(bad_cnt), 32'd0);
    en = 1'b1;
    push(1'b0, 8'h00, "count_wrap");
    drain("count_wrap");
    push(1'b0, 8'h01, "count_after_wrap");
    drain("count_after_wrap");
    push(1'b0, 8'h02, "count_after_wrap");
    drain("count_after_wrap");

    // Reset asserted between edges while tick is high.
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (tick !== 1'b1 && cnt < 20);
    check("tick_before_rst", 32'(tick), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_led4", 32'(led4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (tick !== 1'b1 && cnt < 20);
    check("first_tick_latency", 32'(cnt), 32'd4);
    push(1'b0, 8'h01, "restart_count");
    drain("restart_count");
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (tick !== 1'b1 && cnt < 20);
    check("tick_period", 32'(cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, number of LED outputs (legal range 2..32).
REQ-002 Parameter PRESCALE_BITS, default 23, prescaler width; the step period is 2^PRESCALE_BITS clk cycles.
REQ-003 Parameter PWM_BITS, default 4, brightness resolution.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port en, input, 1, run enable; 0 freezes the prescaler and pattern state.
REQ-007 Port mode, input, 2, pattern select: 0 COUNT, 1 SCAN, 2 FILL, 3 ALT.
REQ-008 Port bright, input, PWM_BITS, LED duty select.
REQ-009 Port led, output, WIDTH, registered LED drive.
REQ-010 Port tick, output, 1, registered one-cycle pulse marking each pattern step.

Function
REQ-011 The prescaler SHALL increment by 1 per clk while en=1, wrap from all-ones to 0, and hold its value while en=0.
REQ-012 tick SHALL be 1 for exactly the one cycle following a cycle in which en=1 and the prescaler equals all-ones; otherwise it SHALL be 0.
REQ-013 The pattern state SHALL advance exactly once per tick-qualifying cycle, i.e. once per 2^PRESCALE_BITS enabled cycles.
REQ-014 COUNT: a WIDTH-bit counter SHALL increment by 1 per step and wrap from 2^WIDTH-1 to 0; pattern = counter.
REQ-015 SCAN: the pattern SHALL be one-hot at index pos (0..WIDTH-1) with direction dir (up = toward the MSB); pos SHALL move by 1 per step, and dir SHALL flip on the step that lands on WIDTH-1 (up to down) or on 0 (down to up).
REQ-016 SCAN sequence for WIDTH=4, from reset: pos 0,1,2,3,2,1,0,1,...; the end positions are not repeated.
REQ-017 FILL: fill SHALL count 0..WIDTH and wrap from WIDTH to 0; pattern = the fill LSBs set, all others clear.
REQ-018 ALT: pattern SHALL alternate between ...0101 (bit0=1) and ...1010, toggling on every step, starting at ...0101.
REQ-019 A registered copy of mode SHALL be kept; when mode differs from it, the block SHALL clear the prescaler and clear all pattern state (counter=0, pos=0, dir=up, fill=0, ALT phase=...0101) that cycle and update the copy. No step SHALL occur in that cycle, even if the prescaler was all-ones.
REQ-020 The PWM counter (PWM_BITS wide) SHALL free-run every clk regardless of en and wrap at all-ones.
REQ-021 The gate SHALL be 1 when bright = all-ones or pwm_cnt < bright, and 0 otherwise; bright=0 SHALL therefore give led=0 permanently.
REQ-022 led SHALL be registered as (pattern & gate), reflecting the pattern and gate values of the previous cycle (1-cycle latency).
REQ-023 When en=0, led SHALL continue to show the frozen pattern under PWM gating.

Reset
REQ-024 Asserting rst SHALL immediately clear the prescaler, the PWM counter, all pattern state, the registered mode (to 0), led and tick, without waiting for clk.
REQ-025 On rst deassertion, the first step SHALL occur 2^PRESCALE_BITS enabled cycles later; rst asserted mid-sequence SHALL abandon the sequence, and the sequence SHALL restart from its reset state.

Verification (PRESCALE_BITS=2, PWM_BITS=4, WIDTH=8)
REQ-026 rst, then en=1, mode=0, bright=15 -> tick every 4 cycles; led = 0,1,2,... each one cycle after its tick; 255 wraps to 0.
REQ-027 mode=1, bright=15, WIDTH=4 build -> led = 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-028 mode=2, bright=15 -> led = 00,01,03,07,...,FF,00 over 9 steps.
REQ-029 mode=0 with led=0x05, switch to mode=3 -> no step that cycle, prescaler restarts; 4 cycles later led=0x55, then 0xAA.
REQ-030 bright=4, mode=0 with counter=0xFF -> led=0xFF for 4 of every 16 cycles, 0 otherwise; bright=0 -> led=0 constantly.
REQ-031 en=0 for 20 cycles mid-sequence, and rst pulsed between clk edges -> pattern holds while en=0; led and tick go to 0 asynchronously on rst.
